// File: rtl/jtframe_vshift_if.sv
// Video bundle between pipeline stages: colour channels plus active-high syncs and blanks.
interface jtframe_vshift_if #(
    parameter int unsigned COLORW = 4
);
    logic [COLORW-1:0] r, g, b;
    logic              hs, vs, hb, vb;

    modport master (output r, g, b, hs, vs, hb, vb);
    modport slave  (input  r, g, b, hs, vs, hb, vb);
endinterface

// File: rtl/jtframe_vshift.sv
// Vertical picture shifter: measures frame geometry in lines and regenerates VS moved by a
// signed line offset. Colour, HS, HB and VB pass through with a one-pixel delay.
module jtframe_vshift #(
    parameter int unsigned COLORW = 4,
    parameter int unsigned VW     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pxl_cen,
    input  logic             enable,
    input  logic [3:0]       voffset,
    jtframe_vshift_if.slave  vin,
    jtframe_vshift_if.master vout
);
    localparam int unsigned TW = VW + 2;

    typedef enum logic [0:0] {StIdle, StPulse} state_e;

    logic [COLORW-1:0] r_q, g_q, b_q;
    logic              hs_q, vs_q, hb_q, vb_q;
    logic              vb_seen_q, vs_line_q, start_seen_q, valid_q, gen_q;
    logic [VW-1:0]     lcnt_q, start_acc_q, len_acc_q, vs_start_q, vs_len_q, off_q, pcnt_q;
    logic [VW:0]       vtotal_q;
    state_e            st_q;

    logic              line_ev, frame_ref, vs_rise_line, geom_match, active, ts_hit;
    logic [VW-1:0]     lcnt_nxt;
    logic [VW:0]       vtotal_new;
    logic [TW-1:0]     diff, ts_x;

    // A VB rise in the same cycle as the HS rise still counts as the frame reference
    assign line_ev      = pxl_cen & vin.hs & ~hs_q;
    assign frame_ref    = line_ev & (vb_seen_q | (vin.vb & ~vb_q));
    assign lcnt_nxt     = frame_ref ? '0 : lcnt_q + VW'(1);
    assign vs_rise_line = vin.vs & ~vs_line_q;
    assign vtotal_new   = {1'b0, lcnt_q} + (VW+1)'(1);
    assign geom_match   = (vtotal_new == vtotal_q) && (start_acc_q == vs_start_q) &&
                          (len_acc_q == vs_len_q);
    assign active       = enable & valid_q & gen_q;

    // Two extra bits keep start - offset exact before the single modulo correction
    always_comb begin
        diff = {2'b00, vs_start_q} - {{2{off_q[VW-1]}}, off_q};
        if (diff[TW-1]) begin
            ts_x = diff + {1'b0, vtotal_q};
        end else if (diff >= {1'b0, vtotal_q}) begin
            ts_x = diff - {1'b0, vtotal_q};
        end else begin
            ts_x = diff;
        end
    end

    assign ts_hit = (ts_x == {2'b00, lcnt_nxt});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_q, g_q, b_q} <= '0;
            {hs_q, hb_q, vb_q} <= '0;
        end else if (pxl_cen) begin
            r_q  <= vin.r;
            g_q  <= vin.g;
            b_q  <= vin.b;
            hs_q <= vin.hs;
            hb_q <= vin.hb;
            vb_q <= vin.vb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vb_seen_q    <= 1'b0;
            vs_line_q    <= 1'b0;
            start_seen_q <= 1'b0;
            valid_q      <= 1'b0;
            gen_q        <= 1'b0;
            lcnt_q       <= '0;
            start_acc_q  <= '0;
            len_acc_q    <= '0;
            vs_start_q   <= '0;
            vs_len_q     <= '0;
            off_q        <= '0;
            vtotal_q     <= '0;
        end else if (pxl_cen) begin
            if (!enable) gen_q <= 1'b0;
            if (line_ev) begin
                vb_seen_q <= 1'b0;
                vs_line_q <= vin.vs;
                lcnt_q    <= lcnt_nxt;
                if (frame_ref) begin
                    vtotal_q     <= vtotal_new;
                    vs_start_q   <= start_acc_q;
                    vs_len_q     <= len_acc_q;
                    off_q        <= {{(VW-4){voffset[3]}}, voffset};
                    valid_q      <= geom_match;
                    gen_q        <= enable;
                    start_acc_q  <= '0;
                    start_seen_q <= vs_rise_line;
                    len_acc_q    <= {{(VW-1){1'b0}}, vin.vs};
                end else begin
                    if (vs_rise_line && !start_seen_q) begin
                        start_acc_q  <= lcnt_nxt;
                        start_seen_q <= 1'b1;
                    end
                    if (vin.vs && len_acc_q != '1) len_acc_q <= len_acc_q + VW'(1);
                end
            end else if (vin.vb && !vb_q) begin
                vb_seen_q <= 1'b1;
            end
        end
    end

    // Generated VS; pass-through whenever shifting is disabled or geometry is unconfirmed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= StIdle;
            vs_q   <= 1'b0;
            pcnt_q <= '0;
        end else if (pxl_cen) begin
            if (!active) begin
                st_q <= StIdle;
                vs_q <= vin.vs;
            end else begin
                unique case (st_q)
                    StIdle: begin
                        if (line_ev && ts_hit && vs_len_q != '0) begin
                            st_q   <= StPulse;
                            vs_q   <= 1'b1;
                            pcnt_q <= vs_len_q;
                        end else begin
                            vs_q <= 1'b0;
                        end
                    end
                    StPulse: begin
                        if (line_ev) begin
                            if (pcnt_q == VW'(1)) begin
                                vs_q <= 1'b0;
                                st_q <= StIdle;
                            end else begin
                                pcnt_q <= pcnt_q - VW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign vout.r  = r_q;
    assign vout.g  = g_q;
    assign vout.b  = b_q;
    assign vout.hs = hs_q;
    assign vout.vs = vs_q;
    assign vout.hb = hb_q;
    assign vout.vb = vb_q;
endmodule

// File: tb/tb_jtframe_vshift.sv
// Frame-level bench for jtframe_vshift: 4-pixel lines, pxl_cen every other clock.
module tb_jtframe_vshift;
    localparam int unsigned COLORW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] voffset = 4'd0;

    jtframe_vshift_if #(.COLORW(COLORW)) vin ();
    jtframe_vshift_if #(.COLORW(COLORW)) vout ();

    jtframe_vshift #(.COLORW(COLORW), .VW(9)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pxl_cen (pxl_cen),
        .enable  (enable),
        .voffset (voffset),
        .vin     (vin),
        .vout    (vout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nlines;
        int         vs_s;
        int         vs_n;
        bit         en;
        logic [3:0] voff;
        int         chg_line; // line at which en/voff are applied
        int         exp_s;    // first generated VS line, -1 = VS_out follows VS_in
        int         exp_n;
    } frame_t;

    int           checks = 0;
    int           errors = 0;
    int           pmis;
    logic [511:0] carry;
    frame_t       tbl[14];

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {vout.r, vout.g, vout.b, vout.hs, vout.vs, vout.hb, vout.vb};
    endfunction

    // One enabled pixel followed by one disabled clock in which outputs must hold
    task automatic drive_pix(input logic hs, input logic vs, input logic hb, input logic vb,
                             output logic vso);
        logic [COLORW-1:0] er, eg, eb;
        logic [15:0]       held;
        @(negedge clk);
        er = COLORW'($urandom);
        eg = COLORW'($urandom);
        eb = COLORW'($urandom);
        vin.r = er; vin.g = eg; vin.b = eb;
        vin.hs = hs; vin.vs = vs; vin.hb = hb; vin.vb = vb;
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        vso = vout.vs;
        if ({vout.r, vout.g, vout.b, vout.hs, vout.hb, vout.vb} !== {er, eg, eb, hs, hb, vb})
            pmis++;
        @(negedge clk);
        pxl_cen = 1'b0;
        held = outs();
        vin.r = COLORW'($urandom); vin.g = COLORW'($urandom); vin.b = COLORW'($urandom);
        @(posedge clk); #1;
        if (outs() !== held) pmis++;
    endtask

    task automatic run_frame(input frame_t f, input int idx, input bit prev_gen,
                             input int rst_line);
        logic [511:0] got, exp, care, nxt_carry;
        logic         vso;
        got = '0; exp = '0; care = '0; nxt_carry = '0;
        pmis = 0;
        if (f.exp_s < 0) begin
            for (int i = 0; i < f.vs_n; i++) exp[f.vs_s + i] = 1'b1;
        end else begin
            exp = carry;
            for (int i = 0; i < f.exp_n; i++) begin
                if (f.exp_s + i < f.nlines) exp[f.exp_s + i] = 1'b1;
                else nxt_carry[f.exp_s + i - f.nlines] = 1'b1;
            end
        end
        for (int l = 0; l < f.nlines; l++) begin
            if (l == f.chg_line) begin
                enable  = f.en;
                voffset = f.voff;
            end
            if (rst_line < 0 || l <= rst_line) care[l] = 1'b1;
            for (int p = 0; p < 4; p++) begin
                drive_pix(p < 2, (l >= f.vs_s) && (l < f.vs_s + f.vs_n), p >= 2, l < 16, vso);
                if (p == 0) got[l] = vso;
                if (l == rst_line && p == 2) begin
                    #1 rst_n = 1'b0;
                    #1 check("reset_mid_pulse", 512'(outs()), 512'd0);
                    #1 rst_n = 1'b1;
                end
            end
        end
        // Mode switches take effect one pixel after the frame reference
        if ((f.exp_s >= 0) != prev_gen) care[0] = 1'b0;
        check($sformatf("vs_frame%0d", idx), got & care, exp & care);
        check($sformatf("passthru_frame%0d", idx), 512'(pmis), 512'd0);
        carry = (f.exp_s < 0) ? '0 : nxt_carry;
    endtask

    initial begin
        frame_t f;
        bit     prev_gen;

        tbl[0]  = '{262, 240, 3, 1'b0, 4'd0,  0,   -1,  0};
        tbl[1]  = '{262, 240, 3, 1'b1, 4'd3,  100, -1,  0};
        tbl[2]  = '{262, 240, 3, 1'b1, 4'd3,  0,   237, 3};
        tbl[3]  = '{262, 240, 3, 1'b1, 4'd3,  0,   237, 3};
        tbl[4]  = '{262, 240, 3, 1'b1, 4'd0,  0,   240, 3};
        tbl[5]  = '{262, 240, 3, 1'b1, 4'hB,  100, 240, 3};
        tbl[6]  = '{262, 240, 3, 1'b1, 4'hB,  0,   245, 3};
        tbl[7]  = '{263, 240, 3, 1'b1, 4'd3,  0,   237, 3};
        tbl[8]  = '{263, 240, 3, 1'b1, 4'd3,  0,   -1,  0};
        tbl[9]  = '{263, 240, 3, 1'b1, 4'd3,  0,   237, 3};
        tbl[10] = '{262, 1,   3, 1'b1, 4'd3,  0,   237, 3};
        tbl[11] = '{262, 1,   3, 1'b1, 4'd3,  0,   -1,  0};
        tbl[12] = '{262, 1,   3, 1'b1, 4'd3,  0,   260, 3};
        tbl[13] = '{262, 1,   3, 1'b1, 4'd3,  0,   260, 3};

        vin.r = '1; vin.g = '1; vin.b = '1;
        vin.hs = 1'b1; vin.vs = 1'b1; vin.hb = 1'b1; vin.vb = 1'b1;
        pxl_cen = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_state", 512'(outs()), 512'd0);
        @(negedge clk);
        vin.r = '0; vin.g = '0; vin.b = '0;
        vin.hs = 1'b0; vin.vs = 1'b0; vin.hb = 1'b0; vin.vb = 1'b0;
        pxl_cen = 1'b0;
        rst_n = 1'b1;

        carry = '0;
        prev_gen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            run_frame(tbl[i], i, prev_gen, -1);
            prev_gen = (tbl[i].exp_s >= 0);
        end

        // Reset while the wrapped pulse is high, then two measured frames before shifting again
        f = '{262, 1, 3, 1'b1, 4'd3, 0, 260, 3};
        run_frame(f, 14, prev_gen, 261);
        carry = '0;
        f = '{262, 1, 3, 1'b1, 4'd3, 0, -1, 0};
        run_frame(f, 15, 1'b0, -1);
        run_frame(f, 16, 1'b0, -1);
        f = '{262, 1, 3, 1'b1, 4'd3, 0, 260, 3};
        run_frame(f, 17, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
